// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: takes the 2-digit BCD count, latches it on a strobe and
// scans it onto a multiplexed 2-digit 7-segment display. Each digit gets PWM
// brightness control. The tens digit can be blanked when it is a leading zero.
// Any nibble above 9 is flagged on err.

// One decoder lane: BCD nibble to segment pattern (bit0=a .. bit6=g).
// Codes 10..15 show a dash so a corrupt count is visible on the display.
module bcd_seg_dec (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   // combinational nibble decode
   always_comb begin
      seg_o = 7'h40;
      case (nib_i)
         4'd0: seg_o = 7'h3F;
         4'd1: seg_o = 7'h06;
         4'd2: seg_o = 7'h5B;
         4'd3: seg_o = 7'h4F;
         4'd4: seg_o = 7'h66;
         4'd5: seg_o = 7'h6D;
         4'd6: seg_o = 7'h7D;
         4'd7: seg_o = 7'h07;
         4'd8: seg_o = 7'h7F;
         4'd9: seg_o = 7'h6F;
         default: seg_o = 7'h40;
      endcase
   end
endmodule

module bcd_seg_scanner #(
   parameter int SCAN_DIV     = 50000,  // clk cycles per digit slot (>= 2)
   parameter int BRIGHT_W     = 3,
   parameter int COMMON_ANODE = 0
) (
   input  logic                clk,
   input  logic                reset,        // synchronous, active-low
   input  logic [7:0]          bcd_in,
   input  logic                bcd_valid,
   input  logic [BRIGHT_W-1:0] brightness,
   input  logic                lz_blank,
   output logic [6:0]          seg,
   output logic [1:0]          digit_en,
   output logic                err,
   output logic                frame_done
);
   localparam int NUM_DIG = 2;
   localparam int PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   // Off level at the pins; XOR with this converts active-high to pin polarity.
   localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0] DEN_OFF = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;

   typedef enum logic {SLOT_ONES = 1'b0, SLOT_TENS = 1'b1} slot_e;

   function automatic logic bcd_bad(input logic [7:0] v);
      return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

   logic [PW-1:0]       presc_q, presc_d;
   slot_e               slot_q,  slot_d;
   logic [7:0]          cap_q,   cap_d;
   logic [7:0]          disp_q,  disp_d;
   logic [BRIGHT_W-1:0] pwm_q,   pwm_d;
   logic                err_q,   err_d;
   logic                fdone_q, fdone_d;
   logic [6:0]          seg_q,   seg_d;
   logic [1:0]          den_q,   den_d;

   logic [NUM_DIG-1:0][6:0] dig_seg;

   // one decoder per digit of the displayed value
   for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
      bcd_seg_dec u_dec (
         .nib_i (disp_q[g*4 +: 4]),
         .seg_o (dig_seg[g])
      );
   end

   logic wrap, boundary, sel, lit, blank;

   // next-state for scan timing, capture/display registers and pin drive
   always_comb begin
      wrap     = (presc_q == PRESC_LAST);
      boundary = wrap && (slot_q == SLOT_TENS);
      sel      = (slot_q == SLOT_TENS);
      lit      = (pwm_q <= brightness);
      blank    = sel && lz_blank && (disp_q[7:4] == 4'd0);

      presc_d = wrap ? '0 : presc_q + PW'(1);
      slot_d  = slot_q;
      if (wrap) slot_d = (slot_q == SLOT_TENS) ? SLOT_ONES : SLOT_TENS;

      // a strobe on the boundary edge lands in cap only; disp takes the old cap
      cap_d   = bcd_valid ? bcd_in : cap_q;
      disp_d  = boundary ? cap_q : disp_q;
      err_d   = boundary ? bcd_bad(cap_q) : err_q;
      fdone_d = boundary;
      pwm_d   = pwm_q + BRIGHT_W'(1);

      seg_d = SEG_OFF;
      den_d = DEN_OFF;
      if (lit && !blank) begin
         seg_d = dig_seg[sel] ^ SEG_OFF;
         den_d = (sel ? 2'b10 : 2'b01) ^ DEN_OFF;
      end
   end

   // state and registered pin outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
         slot_q  <= SLOT_ONES;
         cap_q   <= 8'h00;
         disp_q  <= 8'h00;
         pwm_q   <= '0;
         err_q   <= 1'b0;
         fdone_q <= 1'b0;
         seg_q   <= SEG_OFF;
         den_q   <= DEN_OFF;
      end else begin
         presc_q <= presc_d;
         slot_q  <= slot_d;
         cap_q   <= cap_d;
         disp_q  <= disp_d;
         pwm_q   <= pwm_d;
         err_q   <= err_d;
         fdone_q <= fdone_d;
         seg_q   <= seg_d;
         den_q   <= den_d;
      end
   end

   assign seg        = seg_q;
   assign digit_en   = den_q;
   assign err        = err_q;
   assign frame_done = fdone_q;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: three builds (4-cycle slots, 16-cycle slots,
// common-anode) share stimulus; expected pins come from a cycle-index model.
module tb_bcd_seg_scanner;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] bcd_in;
   logic       bcd_valid;
   logic [2:0] brightness;
   logic       lz_blank;

   logic [6:0] seg_a, seg_b, seg_c;
   logic [1:0] den_a, den_b, den_c;
   logic       err_a, err_b, err_c;
   logic       fd_a,  fd_b,  fd_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_seg_scanner #(.SCAN_DIV(4), .BRIGHT_W(3), .COMMON_ANODE(0)) dut_a (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .brightness(brightness), .lz_blank(lz_blank),
      .seg(seg_a), .digit_en(den_a), .err(err_a), .frame_done(fd_a));

   bcd_seg_scanner #(.SCAN_DIV(16), .BRIGHT_W(3), .COMMON_ANODE(0)) dut_b (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .brightness(brightness), .lz_blank(lz_blank),
      .seg(seg_b), .digit_en(den_b), .err(err_b), .frame_done(fd_b));

   bcd_seg_scanner #(.SCAN_DIV(4), .BRIGHT_W(3), .COMMON_ANODE(1)) dut_c (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .brightness(brightness), .lz_blank(lz_blank),
      .seg(seg_c), .digit_en(den_c), .err(err_c), .frame_done(fd_c));

   // ---------------- reference model ----------------
   // k = clock edges since reset. Slot and PWM phase follow from k directly;
   // pins after edge k reflect the scan state at index k-1.
   int         dv [3] = '{4, 16, 4};
   int         k [3];
   logic [7:0] cap_m [3];
   logic [7:0] disp_m [3];
   logic       e_err [3];
   logic       e_fd [3];
   logic [6:0] e_seg [3];
   logic [1:0] e_den [3];

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (n > 4'd9) ? 7'h40 : t[n];
   endfunction

   function automatic logic on_m(input int kk, input int d, input logic [7:0] disp,
                                 input int br, input logic lz);
      int slot = (kk / d) % 2;
      int pwm  = kk % 8;
      return (pwm <= br) && !(slot == 1 && lz && disp[7:4] == 4'd0);
   endfunction

   function automatic logic [6:0] seg_m(input int kk, input int d, input logic [7:0] disp,
                                        input int br, input logic lz);
      int slot = (kk / d) % 2;
      if (!on_m(kk, d, disp, br, lz)) return 7'h00;
      return seg_of(slot == 1 ? disp[7:4] : disp[3:0]);
   endfunction

   function automatic logic [1:0] den_m(input int kk, input int d, input logic [7:0] disp,
                                        input int br, input logic lz);
      int slot = (kk / d) % 2;
      if (!on_m(kk, d, disp, br, lz)) return 2'b00;
      return (slot == 1) ? 2'b10 : 2'b01;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            k[i] <= 0; cap_m[i] <= 8'h00; disp_m[i] <= 8'h00;
            e_err[i] <= 1'b0; e_fd[i] <= 1'b0; e_seg[i] <= 7'h00; e_den[i] <= 2'b00;
         end else begin
            e_seg[i] <= seg_m(k[i], dv[i], disp_m[i], int'(brightness), lz_blank);
            e_den[i] <= den_m(k[i], dv[i], disp_m[i], int'(brightness), lz_blank);
            k[i]     <= k[i] + 1;
            e_fd[i]  <= ((k[i] + 1) % (2 * dv[i])) == 0;
            if (((k[i] + 1) % (2 * dv[i])) == 0) begin
               disp_m[i] <= cap_m[i];
               e_err[i]  <= (cap_m[i][7:4] > 4'd9) || (cap_m[i][3:0] > 4'd9);
            end
            if (bcd_valid) cap_m[i] <= bcd_in;
         end
      end
   end

   // ---------------- helpers (wait only) ----------------
   task automatic wait_fd(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (fd_a) begin ok = 1'b1; break; end
      end
   endtask

   task automatic strobe(input logic [7:0] v);
      bcd_in = v; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      int npulse;
      reset = 1'b0; bcd_in = 8'h00; bcd_valid = 1'b0; brightness = 3'd7; lz_blank = 1'b0;
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({seg_a, den_a, err_a, fd_a} !== 11'h000) begin
            bad++; $display("FAIL reset_pins: got %h want 000", {seg_a, den_a, err_a, fd_a});
         end
         total++;
         if ({seg_c, den_c, err_c, fd_c} !== {7'h7F, 2'b11, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_pins_ca: got %h/%b want 7f/11", seg_c, den_c);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (seg_a !== 7'h3F || den_a !== 2'b01) begin
         bad++; $display("FAIL first_ones: got %h/%b want 3f/01", seg_a, den_a);
      end
      npulse = 0;
      repeat (16) begin
         @(negedge clk);
         if (fd_a) npulse++;
         total++;
         if ({seg_a, den_a, err_a, fd_a} !== {e_seg[0], e_den[0], e_err[0], e_fd[0]}) begin
            bad++; $display("FAIL first_frame: got %h/%b/%b/%b want %h/%b/%b/%b",
               seg_a, den_a, err_a, fd_a, e_seg[0], e_den[0], e_err[0], e_fd[0]);
         end
      end
      total++;
      if (npulse != 2) begin
         bad++; $display("FAIL fd_period: got %0d pulses want 2", npulse);
      end
   endtask

   task automatic test_digits;
      bit ok1, ok2;
      brightness = 3'd7; lz_blank = 1'b0;
      strobe(8'h47);
      wait_fd(ok1); wait_fd(ok2);
      total++;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL digits_wait: got timeout want frame_done"); end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if ({den_a, seg_a, err_a} !== ((c < 4) ? {2'b01, 7'h07, 1'b0} : {2'b10, 7'h66, 1'b0})) begin
            bad++; $display("FAIL digits_47 c%0d: got %b/%h/%b", c, den_a, seg_a, err_a);
         end
      end
   endtask

   task automatic test_lz_blank;
      bit ok1, ok2;
      brightness = 3'd7; lz_blank = 1'b1;
      strobe(8'h05);
      wait_fd(ok1); wait_fd(ok2);
      total++;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL lz_wait: got timeout want frame_done"); end
      for (int c = 0; c < 16; c++) begin
         if (c == 8) lz_blank = 1'b0;
         @(negedge clk);
         total++;
         if (c < 4 || (c >= 8 && c < 12)) begin
            if ({den_a, seg_a} !== {2'b01, 7'h6D}) begin
               bad++; $display("FAIL lz_ones c%0d: got %b/%h want 01/6d", c, den_a, seg_a);
            end
         end else if (c < 8) begin
            if ({den_a, seg_a} !== {2'b00, 7'h00}) begin
               bad++; $display("FAIL lz_blanked c%0d: got %b/%h want 00/00", c, den_a, seg_a);
            end
         end else if ({den_a, seg_a} !== {2'b10, 7'h3F}) begin
            bad++; $display("FAIL lz_unblank c%0d: got %b/%h want 10/3f", c, den_a, seg_a);
         end
      end
   endtask

   task automatic test_err;
      bit ok1, ok2;
      brightness = 3'd7; lz_blank = 1'b0;
      strobe(8'hA3);
      wait_fd(ok1); wait_fd(ok2);
      total++;
      if (!(ok1 && ok2 && err_a === 1'b1)) begin
         bad++; $display("FAIL err_set: got err=%b want 1", err_a);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if (seg_a !== ((c < 4) ? 7'h4F : 7'h40)) begin
            bad++; $display("FAIL err_digits c%0d: got %h", c, seg_a);
         end
      end
      // new good value: err holds until the next boundary
      bcd_in = 8'h12; bcd_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bcd_valid = 1'b0;
         total++;
         if (c < 7 && err_a !== 1'b1) begin
            bad++; $display("FAIL err_hold c%0d: got %b want 1", c, err_a);
         end else if (c == 7 && {err_a, fd_a} !== 2'b01) begin
            bad++; $display("FAIL err_clear: got err=%b fd=%b want 0/1", err_a, fd_a);
         end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if (seg_a !== ((c < 4) ? 7'h5B : 7'h06)) begin
            bad++; $display("FAIL err_12 c%0d: got %h", c, seg_a);
         end
      end
   endtask

   task automatic test_pwm;
      int lit;
      lz_blank = 1'b0;
      for (int b = 1; b >= 0; b--) begin
         brightness = 3'(b);
         repeat (2) @(negedge clk);
         lit = 0;
         for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (den_b != 2'b00) lit++;
            total++;
            if (den_b !== e_den[1] || seg_b !== e_seg[1] || den_b === 2'b11) begin
               bad++; $display("FAIL pwm_cycle b%0d: got %b/%h want %b/%h", b, den_b, seg_b, e_den[1], e_seg[1]);
            end
         end
         total++;
         if (lit != 8 * (b + 1)) begin
            bad++; $display("FAIL pwm_duty b%0d: got %0d lit want %0d", b, lit, 8 * (b + 1));
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok1, ok2;
      brightness = 3'd7; lz_blank = 1'b0;
      strobe(8'h31);
      wait_fd(ok1); wait_fd(ok2);
      total++;
      if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_wait: got timeout want frame_done"); end
      repeat (7) @(negedge clk);
      bcd_in = 8'h99; bcd_valid = 1'b1;   // lands on the boundary edge
      @(negedge clk);
      bcd_valid = 1'b0;
      total++;
      if (fd_a !== 1'b1) begin bad++; $display("FAIL b2b_edge: got fd=%b want 1", fd_a); end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         total++;
         if (seg_a !== ((c < 4) ? 7'h06 : (c < 8) ? 7'h4F : 7'h6F)) begin
            bad++; $display("FAIL b2b_digits c%0d: got %h", c, seg_a);
         end
      end
      // common-anode build: everything inverted at the pins
      strobe(8'h88);
      wait_fd(ok1); wait_fd(ok2);
      @(negedge clk);
      total++;
      if ({seg_c, den_c} !== {7'h00, 2'b10} || !(ok1 && ok2)) begin
         bad++; $display("FAIL ca_88: got %h/%b want 00/10", seg_c, den_c);
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         total++;
         if ({seg_a, den_a, err_a, fd_a} !== {e_seg[0], e_den[0], e_err[0], e_fd[0]}) begin
            bad++; $display("FAIL rand_a c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
               seg_a, den_a, err_a, fd_a, e_seg[0], e_den[0], e_err[0], e_fd[0]);
         end
         total++;
         if ({seg_b, den_b, err_b, fd_b} !== {e_seg[1], e_den[1], e_err[1], e_fd[1]}) begin
            bad++; $display("FAIL rand_b c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
               seg_b, den_b, err_b, fd_b, e_seg[1], e_den[1], e_err[1], e_fd[1]);
         end
         total++;
         if ({seg_c, den_c, err_c, fd_c} !== {~e_seg[2], ~e_den[2], e_err[2], e_fd[2]}) begin
            bad++; $display("FAIL rand_c c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
               seg_c, den_c, err_c, fd_c, ~e_seg[2], ~e_den[2], e_err[2], e_fd[2]);
         end
         // mid-frame reset pulse, then random stimulus
         reset      = (c != 301);
         bcd_in     = 8'($urandom);
         bcd_valid  = ($urandom_range(0, 3) == 0);
         lz_blank   = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) brightness = 3'($urandom_range(0, 7));
      end
      reset = 1'b1; bcd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_digits();
      test_lz_blank();
      test_err();
      test_pwm();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream consumer of the 2-digit BCD counter's 8-bit count bus: tens in [7:4], ones in [3:0].
- Captures the count on a strobe and drives a time-multiplexed 2-digit 7-segment display, one digit per scan slot.
- Adds per-digit PWM brightness, optional leading-zero blanking and invalid-BCD detection.
- Runs in the 50 MHz clk domain, same clock as the counter.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; frame = 2*SCAN_DIV cycles; minimum 2.
- BRIGHT_W, 3: width of brightness input and free-running PWM counter.
- COMMON_ANODE, 0: 1 inverts seg and digit_en to active-low at the pins.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-low.
- bcd_in  in  8  BCD value; [7:4] tens, [3:0] ones.
- bcd_valid  in  1  capture strobe; bcd_in sampled on any clk edge where high.
- brightness  in  BRIGHT_W  PWM duty code; all-ones = 100%.
- lz_blank  in  1  1 = blank tens digit when it is 0.
- seg  out  7  segments; bit0=a ... bit6=g; active-high when COMMON_ANODE=0.
- digit_en  out  2  bit0 = ones digit, bit1 = tens digit; active-high when COMMON_ANODE=0.
- err  out  1  high while the displayed value contains a nibble > 9.
- frame_done  out  1  1-cycle pulse at each frame boundary.

Behaviour:
- Reset (reset==0 at clk edge):
  - Internal: prescaler=0, slot=ones, capture reg=0x00, display reg=0x00, pwm_cnt=0.
  - Outputs: seg=off, digit_en=off, err=0, frame_done=0. "Off" means pin level 0 when COMMON_ANODE=0, 1 when COMMON_ANODE=1.
  - Reset mid-frame aborts the frame immediately; no frame_done pulse is emitted.
- Capture: when bcd_valid=1, capture reg <= bcd_in. The last strobe before a frame boundary wins.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On wrap, slot toggles ones<->tens.
  - A wrap with slot==tens is a frame boundary.
- Frame boundary:
  - display reg <= capture reg, using the pre-edge capture value. A bcd_valid on the same cycle updates the capture reg only and shows from the next frame.
  - err <= (display nibble tens>9) OR (ones>9), evaluated on the newly loaded value.
  - frame_done asserted for exactly 1 cycle, in the cycle after the boundary edge. Period = 2*SCAN_DIV cycles.
  - The first frame after reset displays 0x00.
- PWM:
  - pwm_cnt is BRIGHT_W bits, free-running +1 per clk and wraps.
  - Digit is lit only when pwm_cnt <= brightness. Duty = (brightness+1)/2^BRIGHT_W.
  - When not lit: digit_en=off and seg=off.
- Decode (nibble -> seg, hex with bit0=a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - 10..15: dash, 40 (g only).
- Leading zero:
  - If lz_blank=1 and display tens==0, the tens slot drives digit_en=off and seg=off for the whole slot.
  - The ones digit is never blanked; 0 shows 3F.
  - lz_blank is sampled live, every cycle.
- Active slot drives exactly one digit_en bit: ones slot -> 01, tens slot -> 10, both subject to PWM and blanking. Never 11.
- Output timing: seg, digit_en and frame_done are registered, 1-cycle latency from internal prescaler/slot/pwm state. No glitches at pins.
- COMMON_ANODE=1: seg and digit_en are the bitwise inverse of the above. err and frame_done are unaffected.

Test Plan:
(SCAN_DIV=4, BRIGHT_W=3 unless noted)
1. Reset low 2 cycles, then high -> seg=00, digit_en=00, err=0, frame_done=0 during reset. First frame shows ones 3F / tens 3F (lz_blank=0), and frame_done pulses every 8 cycles.
2. bcd_in=0x47, bcd_valid 1 cycle, brightness=7 -> from the next boundary: digit_en=01 with seg=07 for 4 cycles, then digit_en=10 with seg=66 for 4 cycles, repeating. err=0.
3. bcd_in=0x05 with lz_blank=1 -> tens slot digit_en=00 and seg=00; ones shows 6D. Toggle lz_blank=0 -> tens shows 3F in the next tens slot.
4. bcd_in=0xA3 -> at the boundary: tens seg=40, ones seg=4F, err=1. Then bcd_in=0x12 -> err stays 1 until the next boundary, then 0 with tens seg=06.
5. SCAN_DIV=16, brightness=1 -> within each slot digit_en is active exactly on pwm_cnt phases 0,1 (2 of 8 cycles). With brightness=0: 1 of 8 cycles.
6. bcd_valid on the exact boundary cycle with 0x99 (previous capture 0x31) -> next frame shows 31, the following frame shows 99. COMMON_ANODE=1 build with 0x88 -> seg=00 (inverse of 7F) and digit_en active-low (10 in ones slot).
